// File: rtl/fetch_stage.sv
// Instruction fetch stage: keeps one instruction request in flight and fills
// the IF/ID register. It can park a response in a hold buffer while decode is
// stalled, and it drops a stale response after a branch redirect.
module fetch_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        BrTaken,
  input  logic        UncondBr,
  input  logic [63:0] brPC,
  input  logic [31:0] brInstr,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [63:0] if_pc,
  output logic [31:0] if_instr,
  output logic [10:0] opCode
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [63:0] pc;
  logic [63:0] pc_next;
  logic [63:0] req_addr;
  logic [63:0] req_addr_next;
  logic [31:0] hold_buf;
  logic [31:0] hold_buf_next;
  logic        if_valid_next;
  logic [63:0] if_pc_next;
  logic [31:0] if_instr_next;
  logic [63:0] br_offset;
  logic [63:0] br_target;
  logic        resp;
  logic        unused_opcode_bits;

  // The branch opcode bits are decoded upstream, so only the immediates are used here.
  assign unused_opcode_bits = ^brInstr[31:26];

  // A request is live in FETCH and DISCARD, and never while reset is held.
  assign imem_req  = reset && (state != HOLD);
  assign imem_addr = req_addr;
  assign resp      = imem_req && imem_valid;
  assign opCode    = if_instr[31:21];

  // Word-scaled, sign-extended branch offset: imm26 for B, imm19 for CB.
  always_comb begin
    if (UncondBr) begin
      br_offset = {{36{brInstr[25]}}, brInstr[25:0], 2'b00};
    end else begin
      br_offset = {{43{brInstr[23]}}, brInstr[23:5], 2'b00};
    end
    br_target = brPC + br_offset;
  end

  // Next-state and datapath decisions. A redirect overrides stall and any capture.
  always_comb begin
    state_next    = state;
    pc_next       = pc;
    req_addr_next = req_addr;
    hold_buf_next = hold_buf;
    if_valid_next = if_valid;
    if_pc_next    = if_pc;
    if_instr_next = if_instr;

    case (state)
      FETCH: begin
        if (BrTaken) begin
          if_valid_next = 1'b0;
          if_instr_next = 32'd0;
          pc_next       = br_target;
          hold_buf_next = 32'd0;
          if (resp) begin
            req_addr_next = br_target;
            state_next    = FETCH;
          end else begin
            state_next = DISCARD;
          end
        end else if (resp && !stall) begin
          if_valid_next = 1'b1;
          if_pc_next    = req_addr;
          if_instr_next = imem_rdata;
          pc_next       = req_addr + 64'd4;
          req_addr_next = req_addr + 64'd4;
        end else if (resp && stall) begin
          hold_buf_next = imem_rdata;
          state_next    = HOLD;
        end else if (!stall) begin
          if_valid_next = 1'b0;
        end
      end

      HOLD: begin
        if (BrTaken) begin
          if_valid_next = 1'b0;
          if_instr_next = 32'd0;
          pc_next       = br_target;
          req_addr_next = br_target;
          hold_buf_next = 32'd0;
          state_next    = FETCH;
        end else if (!stall) begin
          if_valid_next = 1'b1;
          if_pc_next    = req_addr;
          if_instr_next = hold_buf;
          pc_next       = req_addr + 64'd4;
          req_addr_next = req_addr + 64'd4;
          hold_buf_next = 32'd0;
          state_next    = FETCH;
        end
      end

      DISCARD: begin
        if (BrTaken) begin
          if_valid_next = 1'b0;
          if_instr_next = 32'd0;
          pc_next       = br_target;
          hold_buf_next = 32'd0;
        end else begin
          if (!stall) begin
            if_valid_next = 1'b0;
          end
          if (resp) begin
            req_addr_next = pc;
            state_next    = FETCH;
          end
        end
      end

      default: begin
        state_next = FETCH;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= FETCH;
    end else begin
      state <= state_next;
    end
  end

  // PC, request address, hold buffer and IF/ID register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc       <= 64'd0;
      req_addr <= 64'd0;
      hold_buf <= 32'd0;
      if_valid <= 1'b0;
      if_pc    <= 64'd0;
      if_instr <= 32'd0;
    end else begin
      pc       <= pc_next;
      req_addr <= req_addr_next;
      hold_buf <= hold_buf_next;
      if_valid <= if_valid_next;
      if_pc    <= if_pc_next;
      if_instr <= if_instr_next;
    end
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  in  1  synchronous, active-low; sampled only on clk rising edge.
REQ-003 SHALL have port: stall  in  1  hazard hold; freezes PC and IF/ID register.
REQ-004 SHALL have port: BrTaken  in  1  redirect request from the decode stage, already qualified by flags.
REQ-005 SHALL have port: UncondBr  in  1  1 selects imm26 (B), 0 selects imm19 (CB).
REQ-006 SHALL have port: brPC  in  64  PC of the branch instruction in decode.
REQ-007 SHALL have port: brInstr  in  32  branch instruction word in decode.
REQ-008 SHALL have port: imem_req  out  1  instruction memory request.
REQ-009 SHALL have port: imem_addr  out  64  request address.
REQ-010 SHALL have port: imem_valid  in  1  response strobe; exactly one per accepted request; may assert in the same cycle as imem_req.
REQ-011 SHALL have port: imem_rdata  in  32  response instruction word.
REQ-012 SHALL have port: if_valid  out  1  IF/ID entry valid.
REQ-013 SHALL have port: if_pc  out  64  IF/ID PC.
REQ-014 SHALL have port: if_instr  out  32  IF/ID instruction.
REQ-015 SHALL have port: opCode  out  11  always equal to if_instr[31:21]; feeds the control decoder.

Function
REQ-016 SHALL implement states FETCH, HOLD, and DISCARD, plus registers pc, req_addr, and a 32-bit hold buffer.
REQ-017 SHALL hold imem_req high and imem_addr (req_addr) stable in FETCH and DISCARD until imem_valid is sampled high; imem_req SHALL be 0 in HOLD.
REQ-018 In FETCH with imem_valid=1, stall=0, and BrTaken=0, at the next edge the block SHALL:
  - load if_valid=1, if_pc=req_addr, if_instr=imem_rdata;
  - set pc=req_addr+4 and req_addr=req_addr+4;
  - remain in FETCH, giving back-to-back throughput of one instruction per cycle with a zero-wait memory.
REQ-019 In FETCH with imem_valid=1, stall=1, and BrTaken=0, the block SHALL capture imem_rdata into the hold buffer, go to HOLD, and leave IF/ID unchanged.
REQ-020 In FETCH with imem_valid=0 and stall=1, the block SHALL keep requesting and leave IF/ID unchanged.
REQ-021 In HOLD with stall=0, at the next edge the block SHALL:
  - load IF/ID from the hold buffer with pc=req_addr;
  - advance req_addr by 4;
  - enter FETCH.
REQ-022 BrTaken=1 SHALL have priority over stall and over a capture; at the next edge the block SHALL:
  - set if_valid=0 and if_instr=0 (bubble);
  - set pc=target and discard the hold buffer.
REQ-023 On redirect, the next state SHALL be DISCARD if a request is outstanding and imem_valid=0 this cycle; otherwise FETCH with req_addr=target.
REQ-024 In DISCARD, imem_valid SHALL be dropped (no IF/ID update); the block SHALL then enter FETCH with req_addr=pc.
REQ-025 BrTaken in DISCARD SHALL update pc to the new target and keep the state DISCARD.
REQ-026 The branch target SHALL be brPC + (sign-extend-to-64(UncondBr ? brInstr[25:0] : brInstr[23:5]) << 2).
REQ-027 All PC arithmetic SHALL wrap modulo 2^64.
REQ-028 if_pc and if_instr SHALL NOT change while stall=1 and BrTaken=0.

Reset
REQ-029 reset=0 at an edge SHALL set pc=0, req_addr=0, state=FETCH, if_valid=0, if_pc=0, if_instr=0 (so opCode=0), and clear the hold buffer, from any state including mid-request.
REQ-030 imem_req SHALL be 0 while reset=0, and SHALL be 1 with imem_addr=0 in the first cycle after release.
REQ-031 Any imem_valid for a request pending at reset SHALL be ignored unless imem_req=1.

Verification
REQ-032 Reset then a zero-wait memory -> imem_addr sequence 0,4,8,...; if_valid=1 one cycle after release; if_pc sequence 0,4,8; opCode=if_instr[31:21].
REQ-033 stall=1 for 3 cycles while imem_valid=1 at addr 8 -> IF/ID holds pc=4, imem_req=0 during HOLD; after release, if_pc=8 then 12.
REQ-034 BrTaken=1, UncondBr=1, brPC=0x10, imm26=3 -> next edge gives if_valid=0 and if_instr=0; next imem_addr=0x1C.
REQ-035 BrTaken=1, UncondBr=0, brPC=0x40, imm19=0x7FFFE (-2) -> next imem_addr=0x38.
REQ-036 Redirect to 0x100 while a 3-wait request at 0x20 is outstanding -> imem_addr stays 0x20 until valid, response dropped with if_valid=0, then imem_addr=0x100.
REQ-037 reset=0 asserted during HOLD -> all outputs 0 next edge; first request after release at addr 0.
